display_scan_ctrl: RTL and testbench
====================================

# display_scan_ctrl

Time-multiplexing controller for the four-digit common-anode seven-segment display of the adder/subtractor lab. It registers the 9-bit `resultado` and the `Sel_op` flag, and feeds them to the BCD/sign display decoder. It steps the decoder's `sel_disp` through the four digit slots and drives the active-low anode enables, inserting a blanking gap at the start of each slot to suppress ghosting. New results pass through a shadow register and are committed only at frame boundaries, so a frame never shows mixed old and new digits.

## Interface
- `DWELL`, 50000: clock cycles per digit slot; legal values are DWELL ≥ 2.
- `BLANK`, 500: blanked cycles at the start of each slot; legal values are 0 ≤ BLANK < DWELL.
- `clk`  in  1  system clock; all state changes on its rising edge.
- `rst`  in  1  synchronous reset, active-high.
- `en`  in  1  scan enable; 0 turns the display off.
- `load`  in  1  capture strobe for `res_in` and `op_in`; one cycle wide or held.
- `res_in`  in  9  new result; bit 8 is carry/sign, bits [7:0] are magnitude.
- `op_in`  in  1  operation of the new result: 0 = add, 1 = subtract.
- `resultado`  out  9  committed result, driven to the display decoder.
- `Sel_op`  out  1  committed operation, driven to the display decoder.
- `sel_disp`  out  2  digit select: 00 = units, 01 = sign, 10 = hundreds, 11 = tens.
- `an`  out  4  anode enables, active-low; bit 0 is the rightmost digit.
- `pending`  out  1  shadow register holds an uncommitted value.
- `upd_done`  out  1  one-cycle pulse in the cycle a commit becomes visible.
- `frame_tick`  out  1  one-cycle pulse in the first cycle of each wrapped frame.

## Operation
- **Slot counter**
  - `cnt` counts 0..DWELL-1; width is clog2(DWELL).
  - `slot` (equal to `sel_disp`) advances 00→01→10→11→00 when cnt = DWELL-1; cnt returns to 0 on the same edge.
- **Scan state machine**
  - States: OFF, GAP, ON.
  - GAP when en = 1 and cnt < BLANK; ON when en = 1 and cnt ≥ BLANK; OFF when en = 0.
  - With BLANK = 0, GAP never occurs.
- **Anode decode** (all outputs registered)
  - OFF and GAP: `an` = 1111.
  - ON: slot 00 → 1110, slot 11 → 1101, slot 10 → 1011, slot 01 → 0111.
  - Exactly one `an` bit is low in ON.
- **Shadow capture**
  - Any cycle with load = 1 writes `res_in`/`op_in` into the shadow register and sets `pending`.
  - A later load overwrites the shadow; only the last value is committed.
- **Commit**
  - With en = 1: on the edge where slot = 11, cnt = DWELL-1 and pending = 1, copy shadow to `resultado`/`Sel_op`, clear `pending`, assert `upd_done`.
  - With en = 0: commit occurs on the first edge with pending = 1.
- **Simultaneous load and commit**
  - The commit uses the previous shadow value.
  - The new value is captured, and `pending` remains 1.
- **`frame_tick`**
  - Asserted in the first cycle after the slot 11→00 wrap.
  - Never asserted while en = 0, or on the first frame after reset or after en rises.
- **Disable and re-enable**
  - en falling: next edge forces cnt = 0, slot = 00, an = 1111.
  - en rising: the next frame starts at slot 00, cnt = 0, in GAP.

## Timing
- **Reset values** (on the first edge with rst = 1, overriding en and load)
  - `resultado` = 0, `Sel_op` = 0, `sel_disp` = 00, `an` = 1111, `pending` = 0, `upd_done` = 0, `frame_tick` = 0.
  - cnt = 0, shadow = 0.
- **Reset mid-frame**: partial-frame state and any pending shadow are discarded.
- **Reset release**: if en = 1, slot 00 GAP begins in the cycle after rst falls.
- **Latencies**
  - Frame period: 4·DWELL cycles.
  - Each digit is lit for DWELL-BLANK cycles per frame.
  - `sel_disp` changes on the same edge where `an` goes to 1111 (slot start), so decoder segments settle during GAP before the anode enables.
- **Load to display**
  - With en = 1: at most 4·DWELL cycles, plus 1 for the capture edge.
  - With en = 0: 2 edges (capture, then commit).

## Test plan
All scenarios use DWELL = 8, BLANK = 2.
- **Reset and basic scan**: reset, then en = 1 → `an` sequence 1111×2, 1110×6, 1111×2, 0111×6, 1111×2, 1011×6, 1111×2, 1101×6, repeating; `sel_disp` 00,01,10,11; `frame_tick` first high at cycle 32 after release.
- **Frame-boundary commit**: load 9'h1F5 with op = 1 at cycle 5 → `pending` = 1; `resultado` still 0 until the cycle after the slot 11 end (cycle 32); `upd_done` and `frame_tick` both pulse in that cycle.
- **Overwrite and simultaneous commit**: load 9'h00C at cycle 3, then 9'h0FF at cycle 10 → commit shows 9'h0FF. Separately, load 9'h055 on the exact commit edge → the old value commits, `pending` stays 1, and 9'h055 appears at the next frame.
- **Disable mid-slot**: en = 0 at slot 10, cnt = 4 → next cycle `an` = 1111, `sel_disp` = 00; a load while disabled commits 2 edges later with `upd_done`; re-enable → slot 00 GAP with no `frame_tick`.
- **Reset mid-operation**: pending load plus rst during slot 01 ON → all outputs at reset values, `pending` = 0, and the shadow value is never committed.
- **No gap**: BLANK = 0 → no 1111 cycles while en = 1; each anode is lit 8 consecutive cycles.

Source files
------------

// File: rtl/display_scan_ctrl.sv
// Four-digit seven-segment scan controller: steps the digit select, drives active-low anodes
// with a per-slot blanking gap, and commits new results only at frame boundaries.
module display_scan_ctrl #(
   parameter int unsigned DWELL = 50000,
   parameter int unsigned BLANK = 500
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       en,
   input  logic       load,
   input  logic [8:0] res_in,
   input  logic       op_in,
   output logic [8:0] resultado,
   output logic       Sel_op,
   output logic [1:0] sel_disp,
   output logic [3:0] an,
   output logic       pending,
   output logic       upd_done,
   output logic       frame_tick
);

   localparam int unsigned CW = (DWELL > 2) ? $clog2(DWELL) : 1;

   localparam logic [1:0] StOff = 2'd0;
   localparam logic [1:0] StGap = 2'd1;
   localparam logic [1:0] StOn  = 2'd2;

   logic [CW-1:0] cnt_q, cnt_d;
   logic [1:0]    slot_d;
   logic [1:0]    scan_state;
   logic [3:0]    an_d;
   logic [8:0]    shadow_q;
   logic          shadow_op_q;
   logic          last, wrap, commit;

   always_comb begin
      last   = (cnt_q == CW'(DWELL - 1));
      wrap   = en && last && (sel_disp == 2'b11);
      commit = pending && (!en || wrap);

      cnt_d  = cnt_q + CW'(1);
      slot_d = sel_disp;
      if (!en) begin
         cnt_d  = '0;
         slot_d = 2'b00;
      end else if (last) begin
         cnt_d  = '0;
         slot_d = sel_disp + 2'd1;
      end

      // State is evaluated for the cycle being entered so the anode register lines up with cnt.
      if (!en) begin
         scan_state = StOff;
      end else if ((BLANK > 0) && (32'(cnt_d) < BLANK)) begin
         scan_state = StGap;
      end else begin
         scan_state = StOn;
      end

      an_d = 4'b1111;
      if (scan_state == StOn) begin
         unique case (slot_d)
            2'b00: an_d = 4'b1110;
            2'b01: an_d = 4'b0111;
            2'b10: an_d = 4'b1011;
            2'b11: an_d = 4'b1101;
            default: an_d = 4'b1111;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q       <= '0;
         sel_disp    <= 2'b00;
         an          <= 4'b1111;
         resultado   <= '0;
         Sel_op      <= 1'b0;
         shadow_q    <= '0;
         shadow_op_q <= 1'b0;
         pending     <= 1'b0;
         upd_done    <= 1'b0;
         frame_tick  <= 1'b0;
      end else begin
         cnt_q      <= cnt_d;
         sel_disp   <= slot_d;
         an         <= an_d;
         upd_done   <= commit;
         frame_tick <= wrap;
         if (commit) begin
            resultado <= shadow_q;
            Sel_op    <= shadow_op_q;
         end
         // A load on the commit edge is captured after the old shadow has been copied out.
         if (load) begin
            shadow_q    <= res_in;
            shadow_op_q <= op_in;
            pending     <= 1'b1;
         end else if (commit) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_display_scan_ctrl.sv
// Randomized and directed bench for display_scan_ctrl against a frame-position reference model;
// a second instance with BLANK = 0 shares the stimulus.
module tb_display_scan_ctrl;

   localparam int unsigned DWELL = 8;
   localparam int unsigned FRAME = 4 * DWELL;

   logic       clk = 1'b0;
   logic       rst, en, load, op_in;
   logic [8:0] res_in;

   logic [8:0] res_a, res_b;
   logic       op_a, op_b, pend_a, pend_b, upd_a, upd_b, tick_a, tick_b;
   logic [1:0] sel_a, sel_b;
   logic [3:0] an_a, an_b;

   int checks = 0;
   int errors = 0;

   // Reference model: position within the frame plus the commit/shadow rules.
   int         m_pos;
   bit         m_scan;
   logic [8:0] m_res, m_sh;
   logic       m_op, m_shop, m_pend, m_upd, m_tick;

   display_scan_ctrl #(.DWELL(DWELL), .BLANK(2)) dut_a (
      .clk(clk), .rst(rst), .en(en), .load(load), .res_in(res_in), .op_in(op_in),
      .resultado(res_a), .Sel_op(op_a), .sel_disp(sel_a), .an(an_a), .pending(pend_a),
      .upd_done(upd_a), .frame_tick(tick_a)
   );

   display_scan_ctrl #(.DWELL(DWELL), .BLANK(0)) dut_b (
      .clk(clk), .rst(rst), .en(en), .load(load), .res_in(res_in), .op_in(op_in),
      .resultado(res_b), .Sel_op(op_b), .sel_disp(sel_b), .an(an_b), .pending(pend_b),
      .upd_done(upd_b), .frame_tick(tick_b)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   function automatic logic [3:0] exp_an(input int blank);
      if (!m_scan || (m_pos % DWELL) < blank) return 4'b1111;
      case (m_pos / DWELL)
         0:       return 4'b1110;
         1:       return 4'b0111;
         2:       return 4'b1011;
         default: return 4'b1101;
      endcase
   endfunction

   function automatic void model_edge();
      bit commit;
      if (rst) begin
         m_pos = 0; m_scan = 0; m_res = '0; m_op = 0; m_sh = '0; m_shop = 0;
         m_pend = 0; m_upd = 0; m_tick = 0;
         return;
      end
      commit = m_pend && (!en || m_pos == FRAME - 1);
      m_tick = en && (m_pos == FRAME - 1);
      m_upd  = commit;
      if (commit) begin
         m_res = m_sh;
         m_op  = m_shop;
      end
      if (load) begin
         m_sh = res_in; m_shop = op_in; m_pend = 1;
      end else if (commit) begin
         m_pend = 0;
      end
      m_pos  = en ? (m_pos + 1) % FRAME : 0;
      m_scan = en;
   endfunction

   task automatic compare_all();
      check("resultado", 32'(res_a), 32'(m_res));
      check("sel_op", 32'(op_a), 32'(m_op));
      check("sel_disp", 32'(sel_a), 32'(m_pos / DWELL));
      check("an_blank2", 32'(an_a), 32'(exp_an(2)));
      check("an_blank0", 32'(an_b), 32'(exp_an(0)));
      check("pending", 32'(pend_a), 32'(m_pend));
      check("upd_done", 32'(upd_a), 32'(m_upd));
      check("frame_tick", 32'(tick_a), 32'(m_tick));
      check("frame_tick_b", 32'(tick_b), 32'(m_tick));
      check("resultado_b", 32'(res_b), 32'(m_res));
   endtask

   task automatic step();
      @(posedge clk);
      model_edge();
      @(negedge clk);
      compare_all();
   endtask

   task automatic run_to(input int pos);
      int n = 0;
      while (m_pos != pos && n < 2 * FRAME) begin
         step();
         n++;
      end
      check("run_to_bound", 32'(m_pos), 32'(pos));
   endtask

   task automatic do_load(input logic [8:0] v, input logic op);
      load = 1'b1; res_in = v; op_in = op;
      step();
      load = 1'b0;
   endtask

   initial begin
      rst = 1'b1; en = 1'b0; load = 1'b0; res_in = '0; op_in = 1'b0;
      step();
      check("reset_an", 32'(an_a), 32'h0000000F);
      check("reset_res", 32'(res_a), 32'h0);
      rst = 1'b0; en = 1'b1;

      // Commit waits for the end of slot 11
      repeat (5) step();
      do_load(9'h1F5, 1'b1);
      check("held_pending", 32'(pend_a), 32'h1);
      check("held_res", 32'(res_a), 32'h0);
      run_to(0);
      check("frame_commit_res", 32'(res_a), 32'h1F5);
      check("frame_commit_op", 32'(op_a), 32'h1);
      check("frame_commit_upd", 32'(upd_a), 32'h1);
      check("frame_commit_tick", 32'(tick_a), 32'h1);

      // Overwrite, then load on the exact commit edge
      run_to(3);
      do_load(9'h00C, 1'b0);
      run_to(10);
      do_load(9'h0FF, 1'b0);
      run_to(0);
      check("overwrite_res", 32'(res_a), 32'h0FF);
      run_to(FRAME - 2);
      do_load(9'h0AA, 1'b1);
      do_load(9'h055, 1'b0);
      check("simul_old_res", 32'(res_a), 32'h0AA);
      check("simul_pending", 32'(pend_a), 32'h1);
      step();
      run_to(0);
      check("simul_new_res", 32'(res_a), 32'h055);

      // Disable mid-slot, load while off, re-enable
      run_to(2 * DWELL + 4);
      en = 1'b0;
      step();
      check("off_an", 32'(an_a), 32'h0000000F);
      check("off_sel", 32'(sel_a), 32'h0);
      do_load(9'h123, 1'b0);
      step();
      check("off_commit_res", 32'(res_a), 32'h123);
      check("off_commit_upd", 32'(upd_a), 32'h1);
      en = 1'b1;
      repeat (DWELL) begin
         step();
         check("reenable_no_tick", 32'(tick_a), 32'h0);
      end

      // Reset discards a pending shadow
      run_to(DWELL + 4);
      do_load(9'h1AB, 1'b1);
      rst = 1'b1;
      step();
      check("midreset_pending", 32'(pend_a), 32'h0);
      check("midreset_res", 32'(res_a), 32'h0);
      rst = 1'b0;
      repeat (2 * FRAME) step();
      check("midreset_never_commit", 32'(res_a), 32'h0);

      // Random traffic
      for (int i = 0; i < 2000; i++) begin
         rst    = ($urandom_range(0, 299) == 0);
         en     = ($urandom_range(0, 15) != 0);
         load   = ($urandom_range(0, 9) == 0);
         res_in = 9'($urandom);
         op_in  = 1'($urandom);
         step();
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
